fifo_ptr_ctrl: RTL and testbench

//   Pointer and flag controller for the main FIFO. It drives the write, read,
//   wr_ptr and rd_ptr inputs of the RAM memory array, which has a combinational

---
 rtl/fifo_ptr_ctrl_if.sv | 34 +++
 rtl/fifo_ptr_ctrl.sv | 108 ++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake and status bundle between the FIFO pointer controller and its user.
// The controller side uses the slave modport.
interface fifo_ptr_ctrl_if #(
  parameter int MQS = 3
);
  logic           push;
  logic           pop;
  logic [MQS:0]   afull_thr;
  logic [MQS:0]   aempty_thr;
  logic           write;
  logic           read;
  logic [MQS-1:0] wr_ptr;
  logic [MQS-1:0] rd_ptr;
  logic [MQS:0]   count;
  logic           full;
  logic           empty;
  logic           almost_full;
  logic           almost_empty;
  logic           overflow_err;
  logic           underflow_err;
  logic [1:0]     state;

  modport master (
    output push, pop, afull_thr, aempty_thr,
    input  write, read, wr_ptr, rd_ptr, count, full, empty,
           almost_full, almost_empty, overflow_err, underflow_err, state
  );

  modport slave (
    input  push, pop, afull_thr, aempty_thr,
    output write, read, wr_ptr, rd_ptr, count, full, empty,
           almost_full, almost_empty, overflow_err, underflow_err, state
  );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag controller for a FIFO built on a RAM with
// combinational read and clocked write.
//
// state  | meaning
// INIT   | one cycle after reset release; latches thresholds, no accesses
// ACTIVE | qualified push/pop turn into RAM writes/reads
// ERROR  | overflow or underflow seen; everything frozen until reset
module fifo_ptr_ctrl #(
  parameter int MAIN_QUEUE_SIZE = 3
) (
  input  logic          clk,
  input  logic          reset_L,
  fifo_ptr_ctrl_if.slave bus
);
  localparam int MQS = MAIN_QUEUE_SIZE;
  localparam int DEPTH = 2 ** MQS;
  localparam logic [MQS:0] DEPTH_C = (MQS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_ERROR  = 2'b10
  } state_t;

  state_t         state_q;
  logic [MQS-1:0] wr_ptr_q;
  logic [MQS-1:0] rd_ptr_q;
  logic [MQS:0]   count_q;
  logic [MQS:0]   afull_thr_q;
  logic [MQS:0]   aempty_thr_q;
  logic           overflow_q;
  logic           underflow_q;

  logic active;
  logic full_c;
  logic empty_c;
  logic write_c;
  logic read_c;
  logic overflow_evt;
  logic underflow_evt;

  // A push on full is only taken when a pop frees the slot in the same cycle;
  // a pop on empty is never bypassed from a concurrent push.
  always_comb begin
    active        = (state_q == ST_ACTIVE);
    full_c        = (count_q == DEPTH_C);
    empty_c       = (count_q == '0);
    write_c       = active & bus.push & (~full_c | bus.pop);
    read_c        = active & bus.pop & ~empty_c;
    overflow_evt  = active & bus.push & full_c & ~bus.pop;
    underflow_evt = active & bus.pop & empty_c;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= ST_INIT;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      afull_thr_q  <= '0;
      aempty_thr_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          afull_thr_q  <= bus.afull_thr;
          aempty_thr_q <= bus.aempty_thr;
          state_q      <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          wr_ptr_q <= wr_ptr_q + {{(MQS-1){1'b0}}, write_c};
          rd_ptr_q <= rd_ptr_q + {{(MQS-1){1'b0}}, read_c};
          count_q  <= count_q + {{MQS{1'b0}}, write_c} - {{MQS{1'b0}}, read_c};
          if (overflow_evt) begin
            overflow_q <= 1'b1;
          end
          if (underflow_evt) begin
            underflow_q <= 1'b1;
          end
          if (overflow_evt || underflow_evt) begin
            state_q <= ST_ERROR;
          end
        end
        ST_ERROR: begin
          state_q <= ST_ERROR;
        end
        default: begin
          state_q <= ST_ERROR;
        end
      endcase
    end
  end

  assign bus.write         = write_c;
  assign bus.read          = read_c;
  assign bus.wr_ptr        = wr_ptr_q;
  assign bus.rd_ptr        = rd_ptr_q;
  assign bus.count         = count_q;
  assign bus.full          = full_c;
  assign bus.empty         = empty_c;
  // Thresholds are meaningless until latched, so INIT forces the idle values.
  assign bus.almost_full   = (state_q != ST_INIT) & (count_q >= afull_thr_q);
  assign bus.almost_empty  = (state_q == ST_INIT) | (count_q <= aempty_thr_q);
  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: a driver pushes expected outputs from an
// occupancy model, a monitor pops and compares them every cycle.
module tb_fifo_ptr_ctrl;
  localparam int MQS = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_L;

  fifo_ptr_ctrl_if #(.MQS(MQS)) bus ();

  fifo_ptr_ctrl #(.MAIN_QUEUE_SIZE(MQS)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       write;
    logic       read;
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       of;
    logic       uf;
    logic [1:0] state;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // model: 0 init, 1 active, 2 error; occupancy from total accepted accesses
  int m_mode;
  int n_wr;
  int n_rd;
  int m_afq;
  int m_aeq;
  bit m_of;
  bit m_uf;

  function automatic void model_reset();
    m_mode = 0;
    n_wr   = 0;
    n_rd   = 0;
    m_afq  = 0;
    m_aeq  = 0;
    m_of   = 1'b0;
    m_uf   = 1'b0;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("w%0b r%0b wp%0d rp%0d cnt%0d full%0b empty%0b af%0b ae%0b of%0b uf%0b st%0d",
                     o.write, o.read, o.wr_ptr, o.rd_ptr, o.count, o.full, o.empty,
                     o.af, o.ae, o.of, o.uf, o.state);
  endfunction

  task automatic step(input bit p, input bit q, input bit rl);
    obs_t e;
    int   cnt;
    @(posedge clk);
    #1;
    reset_L  = rl;
    bus.push = p;
    bus.pop  = q;
    if (!rl) model_reset();
    cnt      = n_wr - n_rd;
    e.write  = (m_mode == 1) && p && (cnt < DEPTH || q);
    e.read   = (m_mode == 1) && q && (cnt > 0);
    e.wr_ptr = 3'(n_wr % DEPTH);
    e.rd_ptr = 3'(n_rd % DEPTH);
    e.count  = 4'(cnt);
    e.full   = (cnt == DEPTH);
    e.empty  = (cnt == 0);
    e.af     = (m_mode != 0) && (cnt >= m_afq);
    e.ae     = (m_mode == 0) || (cnt <= m_aeq);
    e.of     = m_of;
    e.uf     = m_uf;
    e.state  = 2'(m_mode);
    exp_q.push_back(e);
    if (rl) begin
      case (m_mode)
        0: begin
          m_afq  = int'(bus.afull_thr);
          m_aeq  = int'(bus.aempty_thr);
          m_mode = 1;
        end
        1: begin
          if (e.write) n_wr++;
          if (e.read) n_rd++;
          if (p && cnt == DEPTH && !q) m_of = 1'b1;
          if (q && cnt == 0) m_uf = 1'b1;
          if (m_of || m_uf) m_mode = 2;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.write  = bus.write;
        a.read   = bus.read;
        a.wr_ptr = bus.wr_ptr;
        a.rd_ptr = bus.rd_ptr;
        a.count  = bus.count;
        a.full   = bus.full;
        a.empty  = bus.empty;
        a.af     = bus.almost_full;
        a.ae     = bus.almost_empty;
        a.of     = bus.overflow_err;
        a.uf     = bus.underflow_err;
        a.state  = bus.state;
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cyc%0d: got [%s] want [%s]", vectors, fmt(a), fmt(e));
        end
      end
    end
  end

  initial begin
    int pw;
    int qw;
    reset_L        = 1'b0;
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.afull_thr  = 4'd6;
    bus.aempty_thr = 4'd1;
    model_reset();

    // fill, drain, steady push&pop, then overflow into ERROR
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 1);
    repeat (8) step(1, 0, 1);
    step(1, 1, 1);
    repeat (8) step(0, 1, 1);
    repeat (4) step(1, 0, 1);
    repeat (10) step(1, 1, 1);
    repeat (4) step(1, 0, 1);
    step(1, 0, 1);
    step(1, 1, 1);
    step(0, 1, 1);
    step(1, 0, 1);

    // push&pop on empty
    step(0, 0, 0);
    step(0, 0, 1);
    step(1, 1, 1);
    step(1, 0, 1);

    // reset mid-stream with count=5
    step(0, 0, 0);
    step(1, 0, 1);
    repeat (5) step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 1);
    repeat (3) step(1, 0, 1);

    for (int ep = 0; ep < 25; ep++) begin
      bus.afull_thr  = 4'($urandom_range(0, 15));
      bus.aempty_thr = 4'($urandom_range(0, 15));
      pw = int'($urandom_range(30, 85));
      qw = int'($urandom_range(20, 75));
      step(0, 0, 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      for (int c = 0; c < 40; c++) begin
        step(1'(int'($urandom_range(0, 99)) < pw),
             1'(int'($urandom_range(0, 99)) < qw),
             1'($urandom_range(0, 29) != 0));
      end
    end

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
